rr_flag_gen_bridge: RTL and testbench

Parametrised round-robin priority-pointer generator for the XBAR bridge arbiters; it supersedes the fixed single-request RR flag counter. It tracks an N_MASTER-wide request/grant vector and advances the RR flag on each accepted transfer. Two selectable modes: plain increment, or follow-winner (true round-robin), both with a runtime wrap bound. Adds lock hold, software load, synchronous clear, an update strobe and a sticky protocol-error flag.

---
 rtl/rr_flag_gen_bridge.sv | 125 ++++++++++++
 tb/tb_rr_flag_gen_bridge.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rr_flag_gen_bridge.sv
// -----------------------------------------------------------------------------
// rr_flag_gen_bridge
// Round-robin priority-pointer generator for the XBAR bridge arbiters.
// Tracks an N_MASTER-wide request/grant pair and advances RR_FLAG_o on every
// accepted transfer, either by plain increment (mode_i = 0) or by following
// the winning master (mode_i = 1). Both modes wrap at the runtime bound
// max_idx_i. Also provides lock hold, software load, synchronous clear, a
// one-cycle update strobe and a sticky grant-protocol error flag.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clear_i        synchronous clear of flag and error (highest priority)
//   mode_i         0 = increment, 1 = follow-winner
//   max_idx_i      highest valid flag value
//   data_req_i     per-master request
//   data_gnt_i     per-master grant (expected one-hot or zero)
//   lock_i         hold the flag during locked / multi-beat transfers
//   load_i         load flag from load_val_i
//   load_val_i     value to load (zeroed if above max_idx_i)
//   RR_FLAG_o      registered round-robin pointer
//   flag_update_o  strobe coincident with each newly written RR_FLAG_o
//   gnt_err_o      sticky: multi-hot grant or grant without request seen
// -----------------------------------------------------------------------------
module rr_flag_gen_bridge #(
  parameter int N_MASTER = 8,
  parameter int WIDTH    = $clog2(N_MASTER)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  input  logic                mode_i,
  input  logic [WIDTH-1:0]    max_idx_i,
  input  logic [N_MASTER-1:0] data_req_i,
  input  logic [N_MASTER-1:0] data_gnt_i,
  input  logic                lock_i,
  input  logic                load_i,
  input  logic [WIDTH-1:0]    load_val_i,
  output logic [WIDTH-1:0]    RR_FLAG_o,
  output logic                flag_update_o,
  output logic                gnt_err_o
);

  logic [WIDTH-1:0]    rr_flag_d, rr_flag_q;
  logic                flag_update_d, flag_update_q;
  logic                gnt_err_d, gnt_err_q;

  logic [N_MASTER-1:0] hit;
  logic                hs;
  logic [WIDTH-1:0]    win_idx;
  logic                gnt_multi;
  logic                gnt_orphan;

  // Next pointer after x with wrap at bound. The increment is carried in
  // WIDTH+1 bits so x = 2^WIDTH-1 cannot overflow; x >= bound is the same
  // test as x+1 > bound, which keeps the carry bit in use.
  function automatic logic [WIDTH-1:0] wrap_next(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] bound);
    logic [WIDTH:0] inc;
    inc = {1'b0, x} + {{WIDTH{1'b0}}, 1'b1};
    if (inc > {1'b0, bound}) return '0;
    return inc[WIDTH-1:0];
  endfunction

  assign hit = data_req_i & data_gnt_i;
  assign hs  = |hit;

  // Lowest set bit of hit wins; scanning downward lets the lowest index
  // overwrite any higher one.
  always_comb begin
    win_idx = '0;
    for (int i = N_MASTER - 1; i >= 0; i--) begin
      if (hit[i]) win_idx = WIDTH'(i);
    end
  end

  // x & (x-1) clears the lowest set bit; anything left means multi-hot.
  assign gnt_multi  = |(data_gnt_i & (data_gnt_i - N_MASTER'(1)));
  assign gnt_orphan = |(data_gnt_i & ~data_req_i);

  always_comb begin
    rr_flag_d     = rr_flag_q;
    flag_update_d = 1'b0;
    if (clear_i) begin
      rr_flag_d     = '0;
      flag_update_d = 1'b1;
    end else if (load_i) begin
      rr_flag_d     = (load_val_i > max_idx_i) ? '0 : load_val_i;
      flag_update_d = 1'b1;
    end else if (lock_i) begin
      // Locked transfer: hold, ignoring handshakes and the clamp.
      rr_flag_d     = rr_flag_q;
    end else if (rr_flag_q > max_idx_i) begin
      // Bound lowered below the current pointer; clamp beats a handshake.
      rr_flag_d     = '0;
      flag_update_d = 1'b1;
    end else if (hs) begin
      rr_flag_d     = mode_i ? wrap_next(win_idx, max_idx_i)
                             : wrap_next(rr_flag_q, max_idx_i);
      flag_update_d = 1'b1;
    end
  end

  always_comb begin
    gnt_err_d = gnt_err_q;
    if (clear_i)                      gnt_err_d = 1'b0;
    else if (gnt_multi || gnt_orphan) gnt_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_flag_q     <= '0;
      flag_update_q <= 1'b0;
      gnt_err_q     <= 1'b0;
    end else begin
      rr_flag_q     <= rr_flag_d;
      flag_update_q <= flag_update_d;
      gnt_err_q     <= gnt_err_d;
    end
  end

  assign RR_FLAG_o     = rr_flag_q;
  assign flag_update_o = flag_update_q;
  assign gnt_err_o     = gnt_err_q;

endmodule

// File: tb/tb_rr_flag_gen_bridge.sv
// -----------------------------------------------------------------------------
// Testbench for rr_flag_gen_bridge (N_MASTER = 8). Directed scenarios followed
// by randomized traffic, every cycle compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_rr_flag_gen_bridge;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       mode;
  logic [2:0] max_idx;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       lock;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] flag;
  logic       upd;
  logic       err;

  int checks   = 0;
  int failures = 0;

  // Reference state
  int m_flag = 0;
  int m_upd  = 0;
  int m_err  = 0;

  rr_flag_gen_bridge #(.N_MASTER(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (clear),
    .mode_i       (mode),
    .max_idx_i    (max_idx),
    .data_req_i   (req),
    .data_gnt_i   (gnt),
    .lock_i       (lock),
    .load_i       (load),
    .load_val_i   (load_val),
    .RR_FLAG_o    (flag),
    .flag_update_o(upd),
    .gnt_err_o    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int wrapv(input int x, input int bound);
    return (x >= bound) ? 0 : x + 1;
  endfunction

  // Next-state of the model from the current inputs, straight from the rules.
  task automatic model_step();
    int w;
    int mx;
    logic [7:0] hitv;
    hitv = req & gnt;
    mx   = int'(max_idx);
    w    = -1;
    for (int i = 0; i < 8; i++) if (hitv[i] && w < 0) w = i;
    if (clear) begin
      m_flag = 0; m_upd = 1;
    end else if (load) begin
      m_flag = (int'(load_val) > mx) ? 0 : int'(load_val); m_upd = 1;
    end else if (lock) begin
      m_upd = 0;
    end else if (m_flag > mx) begin
      m_flag = 0; m_upd = 1;
    end else if (w >= 0) begin
      m_flag = mode ? wrapv(w, mx) : wrapv(m_flag, mx); m_upd = 1;
    end else begin
      m_upd = 0;
    end
    if (clear) m_err = 0;
    else if ($countones(gnt) > 1 || (gnt & ~req) != 8'h00) m_err = 1;
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".flag"}, int'(flag), m_flag);
    chk({tag, ".upd"},  int'(upd),  m_upd);
    chk({tag, ".err"},  int'(err),  m_err);
  endtask

  task automatic idle();
    clear = 0; lock = 0; load = 0; load_val = 0;
    req = 8'h00; gnt = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0; mode = 0; max_idx = 3'd7;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.flag", int'(flag), 0);
    chk("rst.upd",  int'(upd),  0);
    chk("rst.err",  int'(err),  0);
    rst_n = 1'b1;

    // Increment mode, master 3 hits every cycle: 1..7,0,1,2
    req = 8'h08; gnt = 8'h08;
    for (int i = 0; i < 10; i++) cyc("inc_seq");
    chk("inc_seq.final", int'(flag), 2);

    // Follow-winner mode
    idle(); clear = 1; cyc("clr0");
    idle(); mode = 1; req = 8'h20; gnt = 8'h20; cyc("fw_m5");
    chk("fw_m5.const", int'(flag), 6);
    req = 8'h80; gnt = 8'h80; cyc("fw_m7");
    chk("fw_m7.const", int'(flag), 0);
    // Grant on master 2 without its request: no handshake, flagged as orphan grant
    req = 8'h00; gnt = 8'h04; cyc("fw_orphan");
    chk("fw_orphan.upd", int'(upd), 0);
    idle(); clear = 1; cyc("clr1");

    // Lock hold, then release with a hit in increment mode
    idle(); mode = 0; load = 1; load_val = 3'd2; cyc("lk_load");
    idle(); lock = 1; req = 8'h11; gnt = 8'h01;
    for (int i = 0; i < 4; i++) cyc("lk_hold");
    lock = 0; cyc("lk_rel");
    chk("lk_rel.const", int'(flag), 3);

    // Load and clamp
    idle(); load = 1; load_val = 3'd6; cyc("ld6");
    chk("ld6.const", int'(flag), 6);
    max_idx = 3'd4; cyc("ld6_max4");
    chk("ld6_max4.const", int'(flag), 0);
    max_idx = 3'd7; cyc("ld6_again");
    idle(); max_idx = 3'd3; req = 8'h02; gnt = 8'h02; cyc("clamp");
    chk("clamp.const", int'(flag), 0);
    // max_idx = 0 keeps flag at 0 but still strobes
    max_idx = 3'd0; cyc("max0");
    chk("max0.upd", int'(upd), 1);

    // Multi-hot grant in follow-winner mode
    idle(); max_idx = 3'd7; mode = 1; req = 8'hFF; gnt = 8'b0001_0100; cyc("mh");
    chk("mh.const", int'(flag), 3);
    idle(); cyc("mh_sticky");
    chk("mh_sticky.err", int'(err), 1);
    clear = 1; gnt = 8'h03; cyc("clr_vs_err");
    chk("clr_vs_err.err", int'(err), 0);

    // Asynchronous reset mid-cycle
    idle(); mode = 0; load = 1; load_val = 3'd5; cyc("pre_rst_load");
    idle(); gnt = 8'h06; req = 8'h00; cyc("pre_rst_err");
    chk("pre_rst.flag", int'(flag), 5);
    chk("pre_rst.err",  int'(err),  1);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.flag", int'(flag), 0);
    chk("arst.upd",  int'(upd),  0);
    chk("arst.err",  int'(err),  0);
    m_flag = 0; m_upd = 0; m_err = 0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    req = 8'h08; gnt = 8'h08; cyc("post_rst");
    chk("post_rst.const", int'(flag), 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      mode     = 1'($urandom % 2);
      max_idx  = ($urandom % 4 == 0) ? 3'($urandom % 8) : 3'd7;
      clear    = ($urandom % 20 == 0);
      load     = ($urandom % 15 == 0);
      load_val = 3'($urandom);
      lock     = ($urandom % 8 == 0);
      req      = 8'($urandom);
      r        = $urandom % 10;
      if (r < 6)      gnt = 8'h01 << ($urandom % 8);
      else if (r < 8) gnt = 8'h00;
      else            gnt = 8'($urandom);
      cyc("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
